// File: rtl/xor_selftest.sv
// xor_selftest: walks every (a, b) pair through an external XOR, checks y_in, reports pass/error count/first failing vector
module xor_selftest #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 0,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y
);
  localparam int VW = 2 * WIDTH;
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic pass_q, pass_d, mis;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fy_q, fy_d;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign a_out     = busy ? v_q[VW-1:WIDTH] : '0;
  assign b_out     = busy ? v_q[WIDTH-1:0] : '0;
  assign mis       = y_in != (a_out ^ b_out);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_y    = fy_q;
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fy_d    = fy_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      v_d     = '0;
      cnt_d   = CW'(SETTLE);
      err_d   = '0;
      pass_d  = 1'b0;
      fa_d    = '0;
      fb_d    = '0;
      fy_d    = '0;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // err_q only ever grows during a run, so zero means no earlier mismatch
        if (mis) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          fa_d  = err_q == '0 ? a_out : fa_q;
          fb_d  = err_q == '0 ? b_out : fb_q;
          fy_d  = err_q == '0 ? y_in : fy_q;
        end
        if (&v_q) begin
          state_d = DONE;
          pass_d  = !mis && err_q == '0;
        end else begin
          v_d   = v_q + 1'b1;
          cnt_d = CW'(SETTLE);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fy_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fy_q    <= fy_d;
    end
  end
endmodule
